mux_4: RTL and testbench

MUX_4 -- requirements
Module: mux_4

---
 rtl/mux_4_pkg.sv | 12 +
 rtl/mux_4.sv | 68 ++++++
 tb/tb_mux_4.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_4_pkg.sv
// Shared select encoding and default sizing for the mux_4 selector.
package mux_4_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    localparam int unsigned DEFAULT_WIDTH = 1;
    localparam int unsigned DEFAULT_CNT_W = 8;

endpackage

// File: rtl/mux_4.sv
// 4:1 selector with registered output/select and a select-change pulse.
// Define MUX_4_CHG_CNT_EN to add the saturating select-change counter chg_cnt.
module mux_4
    import mux_4_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic [1:0]       sel_q,
    output logic             sel_chg
`ifdef MUX_4_CHG_CNT_EN
    ,
    output logic [CNT_W-1:0] chg_cnt
`endif
);

    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("mux_4: CNT_W must be at least 1");
    end

    logic sel_diff;

    always_comb begin
        Y = A;
        case (sel)
            SEL_A:   Y = A;
            SEL_B:   Y = B;
            SEL_C:   Y = C;
            SEL_D:   Y = D;
            default: Y = A;
        endcase
    end

    // After reset sel_q is SEL_A, so the first comparison is against 2'b00.
    assign sel_diff = (sel != sel_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            Y_q     <= '0;
            sel_q   <= SEL_A;
            sel_chg <= 1'b0;
        end else begin
            Y_q     <= Y;
            sel_q   <= sel;
            sel_chg <= sel_diff;
        end
    end

`ifdef MUX_4_CHG_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_cnt <= '0;
        end else if (sel_diff && (chg_cnt != {CNT_W{1'b1}})) begin
            chg_cnt <= chg_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mux_4.sv
// Randomised self-checking bench for mux_4 against a behavioural model.
// Counter checks are active only when MUX_4_CHG_CNT_EN is defined.
module tb_mux_4;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         clk_en = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] A = '0, B = '0, C = '0, D = '0;
    logic [1:0]   sel = 2'b00;
    logic [W-1:0] Y, Y_q;
    logic [1:0]   sel_q;
    logic         sel_chg;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    bit           model_valid = 1'b0;
    logic [W-1:0] m_yq = '0;
    logic [1:0]   m_selq = 2'b00;
    logic         m_chg = 1'b0;
    int           m_cnt8 = 0;
    int           m_cnt2 = 0;

`ifdef MUX_4_CHG_CNT_EN
    logic [7:0] chg_cnt;
    logic [1:0] chg_cnt2;
    logic [W-1:0] y2, yq2;
    logic [1:0]   selq2;
    logic         chg2;
`endif

    mux_4 #(.WIDTH(W), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .sel     (sel),
        .Y       (Y),
        .Y_q     (Y_q),
        .sel_q   (sel_q),
        .sel_chg (sel_chg)
`ifdef MUX_4_CHG_CNT_EN
        ,
        .chg_cnt (chg_cnt)
`endif
    );

`ifdef MUX_4_CHG_CNT_EN
    mux_4 #(.WIDTH(W), .CNT_W(2)) dut_sat (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .sel     (sel),
        .Y       (y2),
        .Y_q     (yq2),
        .sel_q   (selq2),
        .sel_chg (chg2),
        .chg_cnt (chg_cnt2)
    );
`endif

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    function automatic logic [W-1:0] ref_y();
        logic [W-1:0] d [4];
        d = '{A, B, C, D};
        return d[sel];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_yq = '0; m_selq = 2'b00; m_chg = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
            model_valid = 1'b1;
        end else begin
            m_chg = (sel != m_selq);
            if (m_chg) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            m_yq = ref_y();
            m_selq = sel;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_y"}, 32'(Y), 32'(ref_y()));
        if (model_valid) begin
            check({tag, "_yq"}, 32'(Y_q), 32'(m_yq));
            check({tag, "_selq"}, 32'(sel_q), 32'(m_selq));
            check({tag, "_chg"}, 32'(sel_chg), 32'(m_chg));
`ifdef MUX_4_CHG_CNT_EN
            check({tag, "_cnt8"}, 32'(chg_cnt), 32'(m_cnt8));
            check({tag, "_cnt2"}, 32'(chg_cnt2), 32'(m_cnt2));
`endif
        end
    endtask

    // Inputs are driven at the negedge; registered outputs checked at the next negedge.
    task automatic cycle(input string tag);
        @(posedge clk);
        @(negedge clk);
        check_regs(tag);
    endtask

    task automatic drive(input logic r, input logic [1:0] s);
        rst = r;
        sel = s;
    endtask

    initial begin
        logic [W-1:0] y_hold;

        // Pure combinational behaviour with the clock stopped
        A = 4'hF; B = '0; C = '0; D = '0; sel = 2'b00;
        #10 check("comb_a", 32'(Y), 32'hF);
        sel = 2'b01; B = 4'hA; #1 check("comb_b", 32'(Y), 32'hA);
        sel = 2'b10; C = 4'h5; #1 check("comb_c", 32'(Y), 32'h5);
        sel = 2'b11; D = 4'h9; #1 check("comb_d", 32'(Y), 32'h9);
        y_hold = Y;
        A = 4'h3; B = 4'hC; C = 4'h6; #1 check("comb_unsel", 32'(Y), 32'(y_hold));

        // Reset, then hold sel=00 for three cycles
        clk_en = 1'b1;
        @(negedge clk);
        drive(1'b1, 2'b11);
        cycle("rst");
        check("rst_yq", 32'(Y_q), 32'h0);
        check("rst_selq", 32'(sel_q), 32'h0);
        check("rst_chg", 32'(sel_chg), 32'h0);
        drive(1'b0, 2'b00);
        A = 4'h7;
        for (int i = 0; i < 3; i++) begin
            cycle("hold");
            check("hold_chg", 32'(sel_chg), 32'h0);
        end
        check("hold_yq", 32'(Y_q), 32'h7);

        // sel 00 -> 01 -> 01 -> 11
        drive(1'b0, 2'b01); cycle("seq1"); check("seq1_chg", 32'(sel_chg), 32'h1);
        drive(1'b0, 2'b01); cycle("seq2"); check("seq2_chg", 32'(sel_chg), 32'h0);
        drive(1'b0, 2'b11); cycle("seq3"); check("seq3_chg", 32'(sel_chg), 32'h1);
`ifdef MUX_4_CHG_CNT_EN
        check("seq_cnt", 32'(chg_cnt), 32'h2);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, sel + 2'b01);
            cycle("sat");
        end
        check("sat_cnt2", 32'(chg_cnt2), 32'h3);
        check("sat_cnt8", 32'(chg_cnt), 32'h7);
`endif

        // Reset while a change pulse is pending
        drive(1'b0, sel ^ 2'b10); cycle("pre_rst");
        check("pre_rst_chg", 32'(sel_chg), 32'h1);
        drive(1'b1, sel ^ 2'b01);
        B = 4'h1; C = 4'h2; D = 4'h4; A = 4'h8;
        cycle("mid_rst");
        check("mid_rst_yq", 32'(Y_q), 32'h0);
        check("mid_rst_selq", 32'(sel_q), 32'h0);
        check("mid_rst_chg", 32'(sel_chg), 32'h0);
`ifdef MUX_4_CHG_CNT_EN
        check("mid_rst_cnt", 32'(chg_cnt), 32'h0);
`endif
        sel = 2'b10; #1 check("rst_y_tracks", 32'(Y), 32'h2);

        // Randomised traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            A = W'($urandom); B = W'($urandom); C = W'($urandom); D = W'($urandom);
            if ($urandom_range(1, 0) == 1) sel = 2'($urandom);
            rst = ($urandom_range(24, 0) == 0);
            #1 check("rnd_comb", 32'(Y), 32'(ref_y()));
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
